// File: rtl/lht_access_scheduler_if.sv
// Bundle of lookup, update and RAM-side signals for the LHT access scheduler.
// slave is the scheduler's view; master is the surrounding pipeline/RAM view.
interface lht_access_scheduler_if #(
    parameter int IDX_W  = 10,
    parameter int HIST_W = 10,
    parameter int QDEPTH = 4
);
    localparam int CNT_W = $clog2(QDEPTH) + 1;

    logic              lk_valid;
    logic [31:0]       lk_pc;
    logic              lk_ready;
    logic              lk_hist_valid;
    logic [HIST_W-1:0] lk_hist;
    logic              up_valid;
    logic [31:0]       up_pc;
    logic              up_taken;
    logic              up_ready;
    logic [CNT_W-1:0]  q_count;
    logic              init_busy;
    logic              mem_en;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_addr;
    logic [HIST_W-1:0] mem_wdata;
    logic [HIST_W-1:0] mem_rdata;

    modport slave (
        input  lk_valid, lk_pc, up_valid, up_pc, up_taken, mem_rdata,
        output lk_ready, lk_hist_valid, lk_hist, up_ready, q_count, init_busy,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output lk_valid, lk_pc, up_valid, up_pc, up_taken, mem_rdata,
        input  lk_ready, lk_hist_valid, lk_hist, up_ready, q_count, init_busy,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lht_access_scheduler.sv
// Local history table access scheduler: owns the single RAM port and
// interleaves the post-reset fill, fetch lookups and queued read-modify-write
// history updates, with a starvation bound on pending updates.
module lht_access_scheduler #(
    parameter int IDX_W      = 10,
    parameter int HIST_W     = 10,
    parameter int QDEPTH     = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    lht_access_scheduler_if.slave bus
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] QDEPTH_C     = CNT_W'(QDEPTH);
    localparam logic [STV_W-1:0] STARVE_MAX_C = STV_W'(STARVE_MAX);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_UPD_WR} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   sweep_q, sweep_d;
    logic [STV_W-1:0]   starve_q, starve_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               lk_pend_q;
    logic [HIST_W-1:0]  lk_hold_q;
    logic [IDX_W-1:0]   fifo_idx_q [QDEPTH];
    logic               fifo_tkn_q [QDEPTH];

    logic               push, pop, accept, up_ready_c, lk_ready_c;
    logic               mem_en_c, mem_we_c;
    logic [IDX_W-1:0]   mem_addr_c;
    logic [HIST_W-1:0]  mem_wdata_c;
    logic [IDX_W-1:0]   head_idx;
    logic               head_tkn;

    // Only the table index bits of each PC and the shifted-out history bit matter.
    logic unused_bits;
    assign unused_bits = ^{bus.lk_pc[31:IDX_W+2], bus.lk_pc[1:0],
                           bus.up_pc[31:IDX_W+2], bus.up_pc[1:0],
                           bus.mem_rdata[HIST_W-1]};

    assign head_idx = fifo_idx_q[rd_ptr_q];
    assign head_tkn = fifo_tkn_q[rd_ptr_q];

    // Per-slot FIFO storage; slots are overwritten on push, emptiness is tracked by count.
    generate
        for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_slot
            // Capture the update index and direction into this slot when it is the write target.
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_q == PTR_W'(gi))) begin
                    fifo_idx_q[gi] <= bus.up_pc[IDX_W+1:2];
                    fifo_tkn_q[gi] <= bus.up_taken;
                end
            end
        end
    endgenerate

    // Arbitration, RAM command generation and next-state; reset masks every command at once.
    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        starve_d    = starve_q;
        pop         = 1'b0;
        accept      = 1'b0;
        lk_ready_c  = 1'b0;
        mem_en_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        up_ready_c  = (state_q != ST_INIT) && (count_q < QDEPTH_C);
        case (state_q)
            ST_INIT: begin
                mem_en_c    = 1'b1;
                mem_we_c    = 1'b1;
                mem_addr_c  = sweep_q;
                mem_wdata_c = '1;
                sweep_d     = sweep_q + 1'b1;
                if (sweep_q == '1) state_d = ST_RUN;
            end
            ST_RUN: begin
                if ((count_q != '0) && (!bus.lk_valid || starve_q == STARVE_MAX_C)) begin
                    mem_en_c   = 1'b1;
                    mem_addr_c = head_idx;
                    starve_d   = '0;
                    state_d    = ST_UPD_WR;
                end else if (bus.lk_valid) begin
                    lk_ready_c = 1'b1;
                    accept     = 1'b1;
                    mem_en_c   = 1'b1;
                    mem_addr_c = bus.lk_pc[IDX_W+1:2];
                    if ((count_q != '0) && (starve_q != STARVE_MAX_C))
                        starve_d = starve_q + 1'b1;
                end
            end
            ST_UPD_WR: begin
                mem_en_c    = 1'b1;
                mem_we_c    = 1'b1;
                mem_addr_c  = head_idx;
                mem_wdata_c = {bus.mem_rdata[HIST_W-2:0], head_tkn};
                pop         = 1'b1;
                state_d     = ST_RUN;
            end
            default: state_d = ST_INIT;
        endcase
        push = bus.up_valid && up_ready_c;
        if (rst) begin
            push        = 1'b0;
            pop         = 1'b0;
            accept      = 1'b0;
            lk_ready_c  = 1'b0;
            up_ready_c  = 1'b0;
            mem_en_c    = 1'b0;
            mem_we_c    = 1'b0;
            mem_addr_c  = '0;
            mem_wdata_c = '0;
        end
    end

    // State, queue bookkeeping and lookup-return registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            sweep_q   <= '0;
            starve_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            lk_pend_q <= 1'b0;
            lk_hold_q <= '0;
        end else begin
            state_q   <= state_d;
            sweep_q   <= sweep_d;
            starve_q  <= starve_d;
            lk_pend_q <= accept;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            if (lk_pend_q) lk_hold_q <= bus.mem_rdata;
        end
    end

    assign bus.lk_ready      = lk_ready_c;
    assign bus.up_ready      = up_ready_c;
    assign bus.mem_en        = mem_en_c;
    assign bus.mem_we        = mem_we_c;
    assign bus.mem_addr      = mem_addr_c;
    assign bus.mem_wdata     = mem_wdata_c;
    assign bus.q_count       = rst ? '0 : count_q;
    assign bus.init_busy     = rst || (state_q == ST_INIT);
    assign bus.lk_hist_valid = lk_pend_q && !rst;
    assign bus.lk_hist       = rst ? '0 : (lk_pend_q ? bus.mem_rdata : lk_hold_q);
endmodule

// File: doc/lht_access_scheduler.md
Name: lht_access_scheduler

Overview:
Sequences all accesses to the branch predictor's local history table (LHT), held in one synchronous single-port RAM. Three sources share the RAM: fetch-stage history lookups, resolved-branch history updates, and a post-reset initialisation sweep. Updates are queued in a small FIFO and applied as read-modify-write, because the RAM has only one port. A starvation counter bounds how long updates can wait. Sits between fetch/execute and the LHT RAM, ahead of the pattern table indexing logic.

Parameters:
IDX_W, 10, LHT index width; table has 2**IDX_W entries, index = pc[IDX_W+1:2]
HIST_W, 10, history bits per entry
QDEPTH, 4, update FIFO depth (power of two, >=2)
STARVE_MAX, 3, consecutive lookup wins allowed while the queue is non-empty

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
lk_valid  in  1  fetch lookup request
lk_pc  in  32  fetch PC
lk_ready  out  1  lookup accepted this cycle when lk_valid&&lk_ready
lk_hist_valid  out  1  lookup result valid (one cycle after acceptance)
lk_hist  out  HIST_W  history for accepted lookup
up_valid  in  1  resolved conditional branch update
up_pc  in  32  PC of resolved branch
up_taken  in  1  resolved direction
up_ready  out  1  update FIFO can accept
q_count  out  clog2(QDEPTH)+1  FIFO occupancy
init_busy  out  1  initialisation sweep in progress
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable
mem_addr  out  IDX_W  RAM index
mem_wdata  out  HIST_W  RAM write data
mem_rdata  in  HIST_W  RAM read data, valid cycle after a read with mem_en=1, mem_we=0

Behaviour:
- Reset (any cycle, including mid-update): state=INIT, sweep counter=0, FIFO emptied, starve counter=0, lk_hist_valid=0, lk_ready=0, up_ready=0, q_count=0, init_busy=1. Any in-flight lookup result or half-done RMW is dropped.
- Reset values of the remaining outputs: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, lk_hist=0.
- INIT: each cycle write all-ones (HIST_W'b1…1) to mem_addr=sweep counter with mem_en=1 and mem_we=1, then increment the counter.
  - After writing entry 2**IDX_W-1, go to RUN; init_busy drops on that transition.
  - INIT lasts exactly 2**IDX_W cycles. lk_ready=0 and up_ready=0 throughout.
- RUN: arbitrate each cycle.
  - Update grant when the FIFO is non-empty AND (lk_valid==0 OR starve==STARVE_MAX).
    - Issue a read at the head entry's index; lk_ready=0; starve<=0; next state UPD_WR.
  - Otherwise, if lk_valid: lk_ready=1, issue a read at lk_pc[IDX_W+1:2].
    - If the FIFO is non-empty, starve<=starve+1 (saturates at STARVE_MAX).
  - Otherwise the RAM is idle (mem_en=0).
- UPD_WR (one cycle): write {mem_rdata[HIST_W-2:0], head.taken} to the head index, pop the FIFO, return to RUN. lk_ready=0.
- One update therefore occupies 2 cycles. Back-to-back updates to the same index are serialised, so both shifts land.
- Lookup latency: lk_hist_valid=1 exactly one cycle after acceptance, with lk_hist=mem_rdata. Otherwise lk_hist_valid=0 and lk_hist holds its last value.
- No forwarding: a lookup to an index with a queued update returns the pre-update history.
- FIFO:
  - up_ready = (state!=INIT) && (q_count<QDEPTH). It is based on full only; a pop in the same cycle does not free a slot for that cycle.
  - Push when up_valid&&up_ready, storing up_pc[IDX_W+1:2] and up_taken.
  - Simultaneous push and pop leaves q_count unchanged.
  - Pointers wrap modulo QDEPTH.
- up_pc/up_taken are sampled only on push. lk_pc is sampled only on acceptance.

Test Plan:
- Reset sweep: deassert rst, hold lk_valid=1 -> init_busy=1 for exactly 1024 cycles, mem_we=1 with addresses 0..1023, wdata=0x3FF; lk_ready=0 throughout; first lookup of PC 0x40 returns 0x3FF.
- Single update: push pc=0x40, taken=0, with lk_valid=0 -> read of index 16, then write 0x3FE to index 16 the next cycle; q_count returns to 0; a later lookup of 0x40 returns 0x3FE.
- Starvation: lk_valid=1 every cycle, one update queued -> exactly 3 lookups accepted, then lk_ready=0 for 2 cycles while the update completes, then lookups resume.
- FIFO full: push 4 updates during continuous lookups -> up_ready=0 with q_count=4; a 5th push is held off. Updates drain in order; two taken=1 updates to the same index yield ...11 shifted in.
- Simultaneous push and pop at q_count=2 -> q_count stays 2; pointer wrap verified after 9 pushes.
- Mid-operation reset: assert rst during UPD_WR -> no write occurs that cycle; FIFO is empty, lk_hist_valid=0, and the 1024-cycle sweep restarts.
